// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-port Memoria between the CPU datapath
// and the debug/program-loader port, one word access at a time, with
// round-robin arbitration, read-latency wait states, registered read data
// and a saturating CPU stall counter.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_wr,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  cpu_stall_cnt
);

  // Wait counter only needs to hold READ_LAT-1; keep at least one bit.
  localparam int WCNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [WCNT_W-1:0] WAIT_LOAD = WCNT_W'(READ_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT
  } state_t;

  typedef enum logic {
    PORT_CPU,
    PORT_DBG
  } port_t;

  state_t state;
  state_t state_next;
  port_t  owner;
  port_t  last_owner;
  port_t  winner;

  logic              cpu_wins;
  logic              dbg_wins;
  logic              grant_now;
  logic              read_done;
  logic              stall_inc;

  logic              lat_wr;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [WCNT_W-1:0] wait_cnt;

  // Round-robin pick: a lone requester wins, on conflict the port that did not go last wins.
  always_comb begin
    cpu_wins  = 1'b0;
    dbg_wins  = 1'b0;
    winner    = PORT_CPU;
    cpu_wins  = cpu_req && (!dbg_req || (last_owner == PORT_DBG));
    dbg_wins  = dbg_req && !cpu_wins;
    winner    = cpu_wins ? PORT_CPU : PORT_DBG;
  end

  // Next-state logic and decoded memory/grant outputs.
  always_comb begin
    state_next = state;
    grant_now  = 1'b0;
    read_done  = 1'b0;
    cpu_gnt    = 1'b0;
    dbg_gnt    = 1'b0;
    mem_wr     = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (cpu_wins || dbg_wins) begin
          grant_now  = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        cpu_gnt    = (owner == PORT_CPU);
        dbg_gnt    = (owner == PORT_DBG);
        mem_wr     = lat_wr;
        state_next = lat_wr ? IDLE : WAIT;
      end
      WAIT: begin
        if (wait_cnt == '0) begin
          read_done  = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Latch the winning request, track ownership and run the read wait counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      owner      <= PORT_CPU;
      last_owner <= PORT_DBG;
      lat_wr     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      wait_cnt   <= '0;
    end else begin
      if (grant_now) begin
        owner      <= winner;
        last_owner <= winner;
        lat_wr     <= cpu_wins ? cpu_wr    : dbg_wr;
        lat_addr   <= cpu_wins ? cpu_addr  : dbg_addr;
        lat_wdata  <= cpu_wins ? cpu_wdata : dbg_wdata;
      end
      if (state == ACCESS) begin
        wait_cnt <= WAIT_LOAD;
      end else if ((state == WAIT) && (wait_cnt != '0)) begin
        wait_cnt <= wait_cnt - WCNT_W'(1);
      end
    end
  end

  // The memory bus shows the latched request; it holds between accesses.
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;

  // Capture read data for the owning port and pulse its rvalid for one cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
    end else begin
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
      if (read_done) begin
        if (owner == PORT_CPU) begin
          cpu_rvalid <= 1'b1;
          cpu_rdata  <= mem_rdata;
        end else begin
          dbg_rvalid <= 1'b1;
          dbg_rdata  <= mem_rdata;
        end
      end
    end
  end

  // The CPU is stalled whenever it asks and is not the port currently on the memory.
  assign stall_inc = cpu_req && !((state != IDLE) && (owner == PORT_CPU));

  // Saturating stall counter; clear wins over a same-cycle increment.
  always_ff @(posedge clock) begin
    if (reset) begin
      cpu_stall_cnt <= '0;
    end else if (stat_clr) begin
      cpu_stall_cnt <= '0;
    end else if (stall_inc && (cpu_stall_cnt != '1)) begin
      cpu_stall_cnt <= cpu_stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of two arbiter instances, one with a
// single-cycle read latency and a wide counter, one with READ_LAT=3 and a
// 4-bit stall counter.
module tb_mem_port_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Instance A: READ_LAT=1, CNT_W=16
  logic        a_reset, a_cpu_req, a_cpu_wr, a_dbg_req, a_dbg_wr, a_stat_clr;
  logic [31:0] a_cpu_addr, a_cpu_wdata, a_dbg_addr, a_dbg_wdata;
  logic        a_cpu_gnt, a_cpu_rvalid, a_dbg_gnt, a_dbg_rvalid, a_mem_wr, a_busy;
  logic [31:0] a_cpu_rdata, a_dbg_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [15:0] a_stall;

  // Instance B: READ_LAT=3, CNT_W=4
  logic        b_reset, b_cpu_req, b_cpu_wr, b_dbg_req, b_dbg_wr, b_stat_clr;
  logic [31:0] b_cpu_addr, b_cpu_wdata, b_dbg_addr, b_dbg_wdata;
  logic        b_cpu_gnt, b_cpu_rvalid, b_dbg_gnt, b_dbg_rvalid, b_mem_wr, b_busy;
  logic [31:0] b_cpu_rdata, b_dbg_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_stall;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(1), .CNT_W(16)) u_dut_a (
    .clock(clock), .reset(a_reset),
    .cpu_req(a_cpu_req), .cpu_wr(a_cpu_wr), .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata),
    .cpu_gnt(a_cpu_gnt), .cpu_rvalid(a_cpu_rvalid), .cpu_rdata(a_cpu_rdata),
    .dbg_req(a_dbg_req), .dbg_wr(a_dbg_wr), .dbg_addr(a_dbg_addr), .dbg_wdata(a_dbg_wdata),
    .dbg_gnt(a_dbg_gnt), .dbg_rvalid(a_dbg_rvalid), .dbg_rdata(a_dbg_rdata),
    .mem_addr(a_mem_addr), .mem_wr(a_mem_wr), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
    .busy(a_busy), .stat_clr(a_stat_clr), .cpu_stall_cnt(a_stall)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(3), .CNT_W(4)) u_dut_b (
    .clock(clock), .reset(b_reset),
    .cpu_req(b_cpu_req), .cpu_wr(b_cpu_wr), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .cpu_gnt(b_cpu_gnt), .cpu_rvalid(b_cpu_rvalid), .cpu_rdata(b_cpu_rdata),
    .dbg_req(b_dbg_req), .dbg_wr(b_dbg_wr), .dbg_addr(b_dbg_addr), .dbg_wdata(b_dbg_wdata),
    .dbg_gnt(b_dbg_gnt), .dbg_rvalid(b_dbg_rvalid), .dbg_rdata(b_dbg_rdata),
    .mem_addr(b_mem_addr), .mem_wr(b_mem_wr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
    .busy(b_busy), .stat_clr(b_stat_clr), .cpu_stall_cnt(b_stall)
  );

  // Memory model for A: unwritten words read as 0xA5000000 | addr[7:0].
  bit   [31:0] mem_a   [0:255];
  bit          mem_vld [0:255];
  logic [7:0]  a_idx;
  assign a_idx       = a_mem_addr[7:0];
  assign a_mem_rdata = mem_vld[a_idx] ? mem_a[a_idx] : (32'hA500_0000 | {24'h0, a_idx});

  always @(posedge clock) begin
    if (a_mem_wr) begin
      mem_a[a_idx]   <= a_mem_wdata;
      mem_vld[a_idx] <= 1'b1;
    end
  end

  // Memory model for B: read data is the inverted address.
  assign b_mem_rdata = ~b_mem_addr;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_cmp++;
    if (observed !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input bit sel_b,
                               input logic c_req, input logic c_wr,
                               input logic [31:0] c_addr, input logic [31:0] c_wdata,
                               input logic d_req, input logic d_wr,
                               input logic [31:0] d_addr, input logic [31:0] d_wdata);
    if (!sel_b) begin
      a_cpu_req = c_req; a_cpu_wr = c_wr; a_cpu_addr = c_addr; a_cpu_wdata = c_wdata;
      a_dbg_req = d_req; a_dbg_wr = d_wr; a_dbg_addr = d_addr; a_dbg_wdata = d_wdata;
    end else begin
      b_cpu_req = c_req; b_cpu_wr = c_wr; b_cpu_addr = c_addr; b_cpu_wdata = c_wdata;
      b_dbg_req = d_req; b_dbg_wr = d_wr; b_dbg_addr = d_addr; b_dbg_wdata = d_wdata;
    end
  endtask

  task automatic resetDut(input bit sel_b);
    applyStimulus(sel_b, 0, 0, 0, 0, 0, 0, 0, 0);
    if (!sel_b) a_reset = 1'b1; else b_reset = 1'b1;
    tick();
    tick();
    if (!sel_b) a_reset = 1'b0; else b_reset = 1'b0;
  endtask

  initial begin
    a_reset = 1'b1; b_reset = 1'b1; a_stat_clr = 1'b0; b_stat_clr = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // ---- A: reset values, CPU write then read of 0x10
    $display("[TB] A: reset, CPU write and read");
    resetDut(0);
    checkOutput("rst busy", a_busy, 0);
    checkOutput("rst cpu_gnt", a_cpu_gnt, 0);
    checkOutput("rst dbg_gnt", a_dbg_gnt, 0);
    checkOutput("rst mem_wr", a_mem_wr, 0);
    checkOutput("rst mem_addr", a_mem_addr, 0);
    checkOutput("rst mem_wdata", a_mem_wdata, 0);
    checkOutput("rst cpu_rvalid", a_cpu_rvalid, 0);
    checkOutput("rst cpu_rdata", a_cpu_rdata, 0);
    checkOutput("rst dbg_rdata", a_dbg_rdata, 0);
    checkOutput("rst stall", a_stall, 0);

    applyStimulus(0, 1, 1, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, 0);
    tick();
    checkOutput("wr cpu_gnt", a_cpu_gnt, 1);
    checkOutput("wr dbg_gnt", a_dbg_gnt, 0);
    checkOutput("wr mem_wr", a_mem_wr, 1);
    checkOutput("wr mem_addr", a_mem_addr, 32'h10);
    checkOutput("wr mem_wdata", a_mem_wdata, 32'hDEAD_BEEF);
    checkOutput("wr stall", a_stall, 1);
    tick();
    checkOutput("wr c2 busy", a_busy, 0);
    checkOutput("wr c2 mem_wr", a_mem_wr, 0);
    checkOutput("wr c2 stall", a_stall, 1);

    applyStimulus(0, 1, 0, 32'h10, 0, 0, 0, 0, 0);
    tick();
    checkOutput("rd cpu_gnt", a_cpu_gnt, 1);
    checkOutput("rd mem_wr", a_mem_wr, 0);
    checkOutput("rd mem_addr", a_mem_addr, 32'h10);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rd c2 mem_wr", a_mem_wr, 0);
    checkOutput("rd c2 busy", a_busy, 1);
    checkOutput("rd c2 cpu_rvalid", a_cpu_rvalid, 0);
    tick();
    checkOutput("rd c3 cpu_rvalid", a_cpu_rvalid, 1);
    checkOutput("rd c3 cpu_rdata", a_cpu_rdata, 32'hDEAD_BEEF);
    checkOutput("rd c3 dbg_rvalid", a_dbg_rvalid, 0);
    checkOutput("rd c3 busy", a_busy, 0);
    checkOutput("rd c3 stall", a_stall, 2);
    tick();
    checkOutput("rd c4 cpu_rvalid", a_cpu_rvalid, 0);
    checkOutput("rd c4 cpu_rdata hold", a_cpu_rdata, 32'hDEAD_BEEF);

    // ---- A: both ports reading continuously alternate CPU, DBG, CPU, DBG
    $display("[TB] A: round-robin alternation");
    resetDut(0);
    applyStimulus(0, 1, 0, 32'h10, 0, 1, 0, 32'h20, 0);
    for (int c = 1; c <= 12; c++) begin
      int ph;
      tick();
      ph = (c - 1) % 6;
      checkOutput($sformatf("alt c%0d cpu_gnt", c), a_cpu_gnt, (ph == 0) ? 1 : 0);
      checkOutput($sformatf("alt c%0d dbg_gnt", c), a_dbg_gnt, (ph == 3) ? 1 : 0);
      checkOutput($sformatf("alt c%0d cpu_rvalid", c), a_cpu_rvalid, (ph == 2) ? 1 : 0);
      checkOutput($sformatf("alt c%0d dbg_rvalid", c), a_dbg_rvalid, (ph == 5) ? 1 : 0);
      if (ph == 2) checkOutput($sformatf("alt c%0d cpu_rdata", c), a_cpu_rdata, 32'hDEAD_BEEF);
      if (ph == 5) checkOutput($sformatf("alt c%0d dbg_rdata", c), a_dbg_rdata, 32'hA500_0020);
      if (c == 6)  checkOutput("alt c6 stall", a_stall, 4);
      if (c == 12) checkOutput("alt c12 stall", a_stall, 8);
    end
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("alt c13 stall", a_stall, 9);
    tick();
    tick();
    tick();

    // ---- A: CPU request arrives while a debug write is on the memory
    $display("[TB] A: request during debug write");
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'h30, 32'h1234_5678);
    tick();
    checkOutput("dw d1 dbg_gnt", a_dbg_gnt, 1);
    checkOutput("dw d1 mem_wr", a_mem_wr, 1);
    checkOutput("dw d1 mem_addr", a_mem_addr, 32'h30);
    checkOutput("dw d1 mem_wdata", a_mem_wdata, 32'h1234_5678);
    applyStimulus(0, 1, 1, 32'h34, 32'hCAFE_F00D, 1, 1, 32'h30, 32'h1234_5678);
    tick();
    applyStimulus(0, 1, 1, 32'h34, 32'hCAFE_F00D, 0, 0, 0, 0);
    checkOutput("dw d2 mem_wr", a_mem_wr, 0);
    checkOutput("dw d2 cpu_gnt", a_cpu_gnt, 0);
    checkOutput("dw d2 busy", a_busy, 0);
    tick();
    checkOutput("dw d3 cpu_gnt", a_cpu_gnt, 1);
    checkOutput("dw d3 dbg_gnt", a_dbg_gnt, 0);
    checkOutput("dw d3 mem_wr", a_mem_wr, 1);
    checkOutput("dw d3 mem_addr", a_mem_addr, 32'h34);
    checkOutput("dw d3 stall", a_stall, 11);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("dw mem[0x30]", mem_a[8'h30], 32'h1234_5678);
    checkOutput("dw mem[0x34]", mem_a[8'h34], 32'hCAFE_F00D);

    // ---- B: READ_LAT=3 debug read latency, then reset during WAIT
    $display("[TB] B: read latency and reset mid-transaction");
    resetDut(1);
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 32'h20, 0);
    tick();
    checkOutput("b r1 dbg_gnt", b_dbg_gnt, 1);
    checkOutput("b r1 mem_wr", b_mem_wr, 0);
    checkOutput("b r1 mem_addr", b_mem_addr, 32'h20);
    tick();
    tick();
    tick();
    checkOutput("b r4 dbg_rvalid", b_dbg_rvalid, 0);
    checkOutput("b r4 busy", b_busy, 1);
    tick();
    checkOutput("b r5 dbg_rvalid", b_dbg_rvalid, 1);
    checkOutput("b r5 dbg_rdata", b_dbg_rdata, 32'hFFFF_FFDF);
    checkOutput("b r5 cpu_rvalid", b_cpu_rvalid, 0);
    checkOutput("b r5 busy", b_busy, 0);
    tick();
    checkOutput("b r6 dbg_gnt", b_dbg_gnt, 1);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    b_reset = 1'b1;
    tick();
    checkOutput("b r9 busy", b_busy, 0);
    checkOutput("b r9 dbg_rvalid", b_dbg_rvalid, 0);
    checkOutput("b r9 dbg_rdata", b_dbg_rdata, 0);
    checkOutput("b r9 mem_wr", b_mem_wr, 0);
    checkOutput("b r9 dbg_gnt", b_dbg_gnt, 0);
    b_reset = 1'b0;
    tick();
    checkOutput("b r10 dbg_rvalid", b_dbg_rvalid, 0);
    checkOutput("b r10 busy", b_busy, 0);

    // ---- B: 4-bit stall counter saturation and clear
    $display("[TB] B: stall counter saturation and clear");
    resetDut(1);
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 32'h40, 0);
    tick();
    applyStimulus(1, 1, 0, 32'h44, 0, 1, 0, 32'h40, 0);
    for (int s = 2; s <= 46; s++) begin
      tick();
      if (s == 6)  checkOutput("sat s6 cpu_gnt", b_cpu_gnt, 1);
      if (s == 11) checkOutput("sat s11 dbg_gnt", b_dbg_gnt, 1);
      if (s == 30) checkOutput("sat s30 stall", b_stall, 15);
      if (s == 41) begin
        checkOutput("sat s41 stall", b_stall, 15);
        b_stat_clr = 1'b1;
      end
      if (s == 42) begin
        b_stat_clr = 1'b0;
        checkOutput("sat s42 stall cleared", b_stall, 0);
      end
      if (s == 46) checkOutput("sat s46 stall resumed", b_stall, 4);
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
